// File: rtl/max_sort_ctrl.sv
// max_sort_ctrl: bit-serial selection sorter controller.
// A batch of N words of W bits is loaded in one handshake. The words are then
// emitted one at a time over a valid/ready port, largest value first. Each word
// is found by a bit-plane scan that takes one cycle per bit, starting at the MSB.
// When two words hold the same value, the lower index is emitted first.
// Optional build macro MAX_SORT_CTRL_MIN_EN: when it is defined, the scan
// inverts each bit, so the batch is emitted smallest value first.

package sort_pkg;
  localparam int N = 8;
endpackage

module max_sort_ctrl #(
  parameter int N = sort_pkg::N,
  parameter int W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N*W-1:0]       i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [$clog2(N)-1:0] o_idx,
  output logic [W-1:0]         o_data,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int IW = $clog2(N);
  localparam int RW = $clog2(N + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] B_TOP = BW'(W - 1);

`ifdef MAX_SORT_CTRL_MIN_EN
  // Inverting each bit plane makes the scan track the smallest value.
  localparam logic BIT_INV = 1'b1;
`else
  localparam logic BIT_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t         state;
  logic [N*W-1:0] batch;
  logic [N-1:0]   active;
  logic [N-1:0]   chi;
  logic [RW-1:0]  remaining;
  logic [BW-1:0]  b;

  logic [W-1:0]   words [N];
  logic [N-1:0]   col;
  logic           g;
  logic [N-1:0]   chi_next;
  logic [IW-1:0]  sel_idx;
  logic [W-1:0]   sel_data;
  logic [N-1:0]   active_clr;

  // Split the latched batch into words and form the current bit-plane column.
  always_comb begin
    col = '0;
    for (int j = 0; j < N; j++) begin
      words[j] = batch[j*W +: W];
      col[j]   = (words[j][b] ^ BIT_INV) & chi[j];
    end
    g = |col;
    if (g) begin
      chi_next = col;
    end else begin
      chi_next = chi;
    end
  end

  // Pick the lowest-index surviving candidate. The loop runs from the top index
  // down, so the lowest set index is written last and wins ties.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (chi_next[j]) begin
        sel_idx  = IW'(j);
        sel_data = words[j];
      end else begin
        sel_idx  = sel_idx;
        sel_data = sel_data;
      end
    end
  end

  // Active mask with the currently presented word removed.
  always_comb begin
    active_clr = active & ~(N'(1) << o_idx);
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      batch     <= '0;
      active    <= '0;
      chi       <= '0;
      remaining <= '0;
      b         <= B_TOP;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_last    <= 1'b0;
      o_idx     <= '0;
      o_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            batch     <= i_data;
            active    <= '1;
            chi       <= '1;
            remaining <= RW'(N);
            b         <= B_TOP;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          chi <= chi_next;
          if (b == '0) begin
            // The final column is folded in combinationally, so the winner is
            // registered on the same edge that enters EMIT.
            state   <= EMIT;
            o_valid <= 1'b1;
            o_idx   <= sel_idx;
            o_data  <= sel_data;
            o_last  <= (remaining == RW'(1));
          end else begin
            b <= b - BW'(1);
          end
        end
        EMIT: begin
          if (i_ready) begin
            active    <= active_clr;
            remaining <= remaining - RW'(1);
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            if (remaining == RW'(1)) begin
              state   <= IDLE;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              chi   <= active_clr;
              b     <= B_TOP;
              state <= SCAN;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_sort_ctrl.sv
// Self-checking bench for max_sort_ctrl with N=4 and W=4. Expected words go
// into a scoreboard queue when a batch is loaded. Each word the DUT presents
// is popped from that queue and compared. Honours MAX_SORT_CTRL_MIN_EN.
module tb_max_sort_ctrl;
  localparam int N = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [1:0]  o_idx;
  logic [3:0]  o_data;
  logic        o_last;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_cyc = 0;

  logic [1:0] exp_idx  [$];
  logic [3:0] exp_data [$];
  logic       exp_last [$];

  max_sort_ctrl #(.N(N), .W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_idx   (o_idx),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [1:0] idx, input logic [3:0] data, input logic last);
    exp_idx.push_back(idx);
    exp_data.push_back(data);
    exp_last.push_back(last);
  endtask

  // Reference order: repeatedly take the best remaining value; a strict compare keeps the lowest index on ties.
  task automatic model_push(input logic [15:0] d);
    logic [3:0] v [4];
    bit         used [4];
    int         best;
    for (int j = 0; j < 4; j++) begin
      v[j] = d[j*4 +: 4];
      used[j] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      best = -1;
      for (int j = 0; j < 4; j++) begin
        if (!used[j]) begin
          if (best < 0) best = j;
`ifdef MAX_SORT_CTRL_MIN_EN
          else if (v[j] < v[best]) best = j;
`else
          else if (v[j] > v[best]) best = j;
`endif
        end
      end
      used[best] = 1'b1;
      push_exp(2'(best), v[best], k == 3);
    end
  endtask

  task automatic load(input logic [15:0] d);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready got %b want 1", o_ready);
    end
    i_valid = 1'b1;
    i_data  = d;
    ref_cyc = cyc;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = ~d;
    checks++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_busy got busy=%b ready=%b want busy=1 ready=0", o_busy, o_ready);
    end
  endtask

  task automatic drain(input int n, input bit stall);
    int         wait_n;
    logic [1:0] ei;
    logic [3:0] ed;
    logic       el;
    i_ready = stall ? 1'b0 : 1'b1;
    for (int w = 0; w < n; w++) begin
      wait_n = 0;
      do begin
        @(negedge clk);
        wait_n++;
      end while (o_valid !== 1'b1 && wait_n < 40);
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL valid_timeout word %0d got o_valid=%b want 1", w, o_valid);
        i_ready = 1'b1;
        return;
      end
      checks++;
      if (cyc - ref_cyc != W + 1) begin
        errors++;
        $display("FAIL latency word %0d got %0d want %0d", w, cyc - ref_cyc, W + 1);
      end
      checks++;
      if (exp_idx.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got idx=%0d data=%0d want none", o_idx, o_data);
        return;
      end
      ei = exp_idx.pop_front();
      ed = exp_data.pop_front();
      el = exp_last.pop_front();
      checks++;
      if (o_idx !== ei || o_data !== ed || o_last !== el || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL word %0d got idx=%0d data=%0d last=%b busy=%b want idx=%0d data=%0d last=%b busy=1",
                 w, o_idx, o_data, o_last, o_busy, ei, ed, el);
      end
      if (stall && w == 0) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if (o_valid !== 1'b1 || o_idx !== ei || o_data !== ed || o_last !== el) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got v=%b idx=%0d data=%0d want v=1 idx=%0d data=%0d",
                     s, o_valid, o_idx, o_data, ei, ed);
          end
        end
        i_ready = 1'b1;
      end
      ref_cyc = cyc;
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL end_idle got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0", o_valid, o_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_ready, o_valid, o_busy, o_last, o_idx, o_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b busy=%b last=%b idx=%0d data=%0d want 1 0 0 0 0 0",
               o_ready, o_valid, o_busy, o_last, o_idx, o_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic push_3991();
`ifdef MAX_SORT_CTRL_MIN_EN
    push_exp(2'd3, 4'd1, 1'b0); push_exp(2'd0, 4'd3, 1'b0);
    push_exp(2'd1, 4'd9, 1'b0); push_exp(2'd2, 4'd9, 1'b1);
`else
    push_exp(2'd1, 4'd9, 1'b0); push_exp(2'd2, 4'd9, 1'b0);
    push_exp(2'd0, 4'd3, 1'b0); push_exp(2'd3, 4'd1, 1'b1);
`endif
  endtask

  task automatic test_basic();
    push_3991();
    load({4'd1, 4'd9, 4'd9, 4'd3});
    drain(4, 1'b0);
  endtask

  task automatic test_stall();
    push_3991();
    load({4'd1, 4'd9, 4'd9, 4'd3});
    drain(4, 1'b1);
  endtask

  task automatic test_zero();
    push_exp(2'd0, 4'd0, 1'b0); push_exp(2'd1, 4'd0, 1'b0);
    push_exp(2'd2, 4'd0, 1'b0); push_exp(2'd3, 4'd0, 1'b1);
    load(16'h0000);
    drain(4, 1'b0);
  endtask

  task automatic test_mid_reset();
    int seen;
    i_ready = 1'b1;
    load({4'd1, 4'd9, 4'd9, 4'd3});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b v=%b busy=%b want 1 0 0", o_ready, o_valid, o_busy);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abandoned_batch got %0d valid cycles want 0", seen);
    end
`ifdef MAX_SORT_CTRL_MIN_EN
    push_exp(2'd1, 4'd2, 1'b0); push_exp(2'd0, 4'd5, 1'b0);
    push_exp(2'd2, 4'd7, 1'b0); push_exp(2'd3, 4'd7, 1'b1);
`else
    push_exp(2'd2, 4'd7, 1'b0); push_exp(2'd3, 4'd7, 1'b0);
    push_exp(2'd0, 4'd5, 1'b0); push_exp(2'd1, 4'd2, 1'b1);
`endif
    load({4'd7, 4'd7, 4'd2, 4'd5});
    drain(4, 1'b0);
  endtask

  task automatic test_ignore_busy();
    push_3991();
    load({4'd1, 4'd9, 4'd9, 4'd3});
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", o_ready);
    end
    i_valid = 1'b1;
    i_data  = {4'd15, 4'd0, 4'd0, 4'd14};
    @(negedge clk);
    i_valid = 1'b0;
    drain(4, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    for (int r = 0; r < 6; r++) begin
      d = 16'($urandom) & ((r % 2 == 1) ? 16'h3333 : 16'hFFFF);
      model_push(d);
      load(d);
      drain(4, r % 3 == 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_mid_reset();
    test_ignore_busy();
    test_back_to_back();
    checks++;
    if (exp_idx.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_idx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_sort_ctrl.md
MAX_SORT_CTRL -- requirements
Module: max_sort_ctrl

Interface
REQ-001 Parameter N, default sort_pkg::N (8), number of words sorted per batch; N >= 2.
REQ-002 Parameter W, default 8, word width in bits; W >= 1.
REQ-003 Port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1, reset; synchronous, active-low.
REQ-005 Port i_valid, input, 1, batch load request.
REQ-006 Port o_ready, output, 1, controller accepts a batch (high only in IDLE).
REQ-007 Port i_data, input, N*W, batch; word j occupies bits [j*W+W-1 : j*W].
REQ-008 Port o_valid, output, 1, result word presented.
REQ-009 Port i_ready, input, 1, downstream accepts the result.
REQ-010 Port o_idx, output, $clog2(N), index of the presented word in the loaded batch.
REQ-011 Port o_data, output, W, value of the presented word.
REQ-012 Port o_last, output, 1, presented word is the final one of the batch.
REQ-013 Port o_busy, output, 1, high in every state except IDLE.

Function
REQ-014 The FSM shall have states IDLE, SCAN and EMIT, with all state bits registered.
- IDLE: o_ready = 1.
- On i_valid && o_ready: latch i_data, set active mask to all ones, set remaining = N, set candidate mask chi = active, set bit pointer b = W-1, go to SCAN.
REQ-015 SCAN shall process one bit plane per cycle, MSB first.
- col[j] = word_j[b] & chi[j]; g = |col.
- If g = 1, chi <= col; otherwise chi is unchanged (selection-block semantics).
- When b = 0, go to EMIT; otherwise decrement b.
REQ-016 On entry to EMIT, the lowest set index of chi shall be selected (ties resolve to the lowest index), and o_idx/o_data shall be registered from it.
REQ-017 o_valid shall be high throughout EMIT. o_idx, o_data and o_last shall hold stable until o_valid && i_ready.
REQ-018 On the EMIT handshake:
- clear active[o_idx] and decrement remaining.
- If remaining was 1, go to IDLE.
- Otherwise reload chi = updated active, b = W-1, and go to SCAN.
REQ-019 o_last shall be 1 exactly when remaining = 1 during EMIT.
REQ-020 Latency: the first o_valid shall rise W+1 cycles after the load handshake cycle. Each subsequent word shall follow W+1 cycles after the previous handshake when i_ready = 1.
REQ-021 i_valid shall be ignored outside IDLE, and i_data shall not be resampled.
REQ-022 Equal values shall be emitted in ascending index order. An all-zero batch shall emit indices 0..N-1.
REQ-023 i_ready asserted outside EMIT shall have no effect.

Reset
REQ-024 With i_rst_n = 0 at a clock edge, the next state shall be:
- IDLE; o_ready = 1; o_valid = 0; o_busy = 0; o_last = 0; o_idx = 0; o_data = 0.
- active, chi and remaining = 0; b = W-1.
REQ-025 Reset asserted in any state, including mid-SCAN and mid-EMIT, shall abandon the batch with no further outputs.

Configuration
REQ-026 Macro MAX_SORT_CTRL_MIN_EN:
- Defined: SCAN uses inverted bits (col[j] = ~word_j[b] & chi[j]), so the batch is emitted in ascending value order (minimum first); ties still resolve to the lowest index.
- Undefined: the batch is emitted maximum first, as in REQ-015.

Verification (N=4, W=4)
REQ-027 Load {w0=3, w1=9, w2=9, w3=1} with i_ready = 1 -> (idx,data) = (1,9), (2,9), (0,3), (3,1); o_last only on (3,1); first o_valid 5 cycles after load.
REQ-028 Same batch, i_ready held low 3 cycles during the first EMIT -> o_idx = 1 and o_data = 9 held stable; second word appears 5 cycles after the handshake.
REQ-029 Load {0,0,0,0} -> indices 0, 1, 2, 3, each with data 0.
REQ-030 Assert i_rst_n = 0 during the third SCAN cycle -> next cycle: IDLE, o_ready = 1, o_valid = 0; a new batch {5,2,7,7} then yields (2,7), (3,7), (0,5), (1,2).
REQ-031 Pulse i_valid with different data while busy -> ignored; the original batch output is unchanged.
REQ-032 With MAX_SORT_CTRL_MIN_EN defined, load {3,9,9,1} -> (3,1), (0,3), (1,9), (2,9).
